wrr_client_requester: RTL and testbench
=======================================

Name: wrr_client_requester

Overview:
- Client-side agent for the 8-way weighted round-robin arbiter. One instance sits at each arbiter requestor port.
- Buffers beats from a local producer in a small FIFO and drives that port's req bit while data is pending.
- On each registered grant pulse, pops one beat onto the shared bus.
- Also reports spurious grants and request starvation.

Parameters:
- DATA_W, 32, width of payload beat
- DEPTH, 4, FIFO entries (power of 2, >=2)
- CNT_W, 11, starvation counter and limit width (matches arbiter weight width)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer beat valid
- in_ready  out  1  FIFO can accept beat
- in_data  in  DATA_W  producer payload
- in_last  in  1  last beat of packet
- req  out  1  request to arbiter port
- grant  in  1  registered one-cycle grant from arbiter port
- out_valid  out  1  beat driven on shared bus
- out_data  out  DATA_W  shared bus payload
- out_last  out  1  packet boundary on shared bus
- cfg_starve_limit  in  CNT_W  starvation threshold; 0 disables
- starve  out  1  req pending for >= limit cycles without grant
- err_spurious  out  1  sticky: grant seen while FIFO empty

Behaviour:
- Reset: FIFO empty, all outputs 0. in_ready rises in the first cycle after reset release.
- Push: in_valid & in_ready writes {in_last, in_data} at the tail.
  - in_ready = !full, computed from the current count only.
  - A push while full is blocked even if a pop happens in the same cycle.
- Request: req = (count != 0), combinational from the registered count. There is no internal state machine beyond FIFO pointers and counters.
- Grant with FIFO non-empty: pop head.
  - Next cycle: out_valid=1, out_data/out_last = popped entry (1-cycle latency, registered).
  - Otherwise out_valid=0; out_data/out_last hold their last value.
- Arbiter cannot grant back-to-back, so a single entry is never double-popped.
  - Last entry popped at cycle t: req=0 from t+1.
  - Arbiter's next-cycle grant is masked.
- Grant with FIFO empty: no pop, out_valid stays 0, err_spurious sets and remains 1 until reset.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - A push into an empty FIFO makes req=1 the next cycle. Push data is never bypassed to out_data in the same cycle.
- Pointer arithmetic: log2(DEPTH)-bit pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Starvation counter (CNT_W bits):
  - Increments each cycle req=1 & grant=0, saturating at all-ones.
  - Clears to 0 on grant or req=0.
  - starve = (cfg_starve_limit != 0) & (cnt >= cfg_starve_limit), registered as a compare on the counter. It drops the cycle after the counter clears.
- cfg_starve_limit may change at any time and takes effect in the next comparison.
- Reset mid-operation: FIFO contents discarded, pointers/count/counter/err cleared, req drops asynchronously with the count.

Decomposition:
- Shared package:
  - beat struct type {last, data}
  - localparam PTR_W = $clog2(DEPTH)
  - starvation counter max constant
- One sub-module: wrr_client_fifo (sync FIFO with push/pop/full/empty/count). The top adds req, output register, starvation counter and error flag.

Test Plan:
1. Reset, then push 3 beats D0..D2 (last on D2), no grants -> req=1 from the cycle after the first push, count=3. Grants on cycles 10,12,14 -> out_valid on 11,13,15 with D0,D1,D2; out_last only on 15; req=0 from cycle 15.
2. Fill DEPTH=4 -> in_ready=0. Push attempt with grant in the same cycle -> push rejected, count=3 next cycle, in_ready=1.
3. Grant pulse with FIFO empty -> no out_valid; err_spurious=1 and stays 1 through further traffic until rst_n low.
4. cfg_starve_limit=5, one beat pending, no grant -> starve=1 once the counter reaches 5. Grant -> starve=0 the cycle after the counter clears. With limit=0 the same stimulus keeps starve=0.
5. Pointer wrap: 10 push/grant cycles interleaved with simultaneous push and pop -> output order matches input order, count never exceeds 4.
6. Assert rst_n low with 2 beats pending -> req, out_valid, starve, err_spurious all 0 immediately. After release, FIFO is empty and a grant pops nothing.

Source files
------------

// File: rtl/wrr_client_requester_pkg.sv
// Shared types and constants for the weighted round-robin client requester.
// Beat layout, FIFO pointer sizing and starvation counter helpers.
package wrr_client_requester_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 11;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FILL_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Saturating increment for the starvation counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_client_fifo.sv
// Small synchronous FIFO holding {last, data} beats for the client requester.
// Push is ignored when full and pop is ignored when empty.
module wrr_client_fifo
    import wrr_client_requester_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [DATA_W:0] wdata_i,
    input  logic            pop_i,
    output logic [DATA_W:0] rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [PTR_W:0]  count_o
);

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_s, pop_s;

    assign full_o  = (count_q == FILL_FULL);
    assign empty_o = (count_q == FILL_ZERO);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next-state pointers and fill level; a full FIFO refuses pushes even when popping.
    always_comb begin
        push_s   = push_i & ~full_o;
        pop_s    = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + FILL_ONE;
            2'b01:   count_d = count_q - FILL_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and fill level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= FILL_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(DATA_W+1){1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/wrr_client_requester.sv
// Client agent for one port of the 8-way weighted round-robin arbiter: buffers
// producer beats, requests while data is pending, pops a beat per grant pulse.
module wrr_client_requester
    import wrr_client_requester_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              req_o,
    input  logic              grant_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic [CNT_W-1:0]  cfg_starve_limit_i,
    output logic              starve_o,
    output logic              err_spurious_o
);

    logic             ready_en_q;
    logic             out_valid_q, out_valid_d;
    beat_t            out_beat_q, out_beat_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starve_q, starve_d;

    logic             push_s, pop_s, full_s, empty_s;
    logic [PTR_W:0]   count_s;
    logic [DATA_W:0]  rdata_s;
    beat_t            in_beat_s, head_s;

    assign in_beat_s = '{last: in_last_i, data: in_data_i};
    assign head_s    = rdata_s;

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready_o = ready_en_q & ~full_s;
    assign push_s     = in_valid_i & in_ready_o;
    assign pop_s      = grant_i & ~empty_s;
    assign req_o      = (count_s != FILL_ZERO);

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_beat_q.data;
    assign out_last_o     = out_beat_q.last;
    assign starve_o       = starve_q;
    assign err_spurious_o = err_q;

    wrr_client_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (in_beat_s),
        .pop_i   (pop_s),
        .rdata_o (rdata_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Output beat capture, spurious-grant flag and starvation tracking.
    always_comb begin
        out_valid_d = 1'b0;
        out_beat_d  = out_beat_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        starve_d    = 1'b0;
        if (pop_s) begin
            out_valid_d = 1'b1;
            out_beat_d  = head_s;
        end else begin
            out_valid_d = 1'b0;
            out_beat_d  = out_beat_q;
        end
        if (grant_i & empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (req_o & ~grant_i) begin
            cnt_d = cnt_sat_inc(cnt_q);
        end else begin
            cnt_d = CNT_ZERO;
        end
        starve_d = (cfg_starve_limit_i != CNT_ZERO) & (cnt_q >= cfg_starve_limit_i);
    end

    // Registered outputs and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_beat_q  <= '{last: 1'b0, data: {DATA_W{1'b0}}};
            err_q       <= 1'b0;
            cnt_q       <= CNT_ZERO;
            starve_q    <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
        end
    end

endmodule

// File: tb/tb_wrr_client_requester.sv
// Directed and randomized bench for wrr_client_requester against a queue-based
// reference model; every cycle compares all outputs with the model's prediction.
module tb_wrr_client_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        req;
    logic        grant;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [10:0] limit;
    logic        starve;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [32:0] mq[$];
    bit          m_en;
    bit          m_ov;
    logic [31:0] m_od;
    bit          m_ol;
    bit          m_err;
    int          m_cnt;
    bit          m_starve;
    bit          prev_g;

    always #5 clk = ~clk;

    wrr_client_requester dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_data_i          (in_data),
        .in_last_i          (in_last),
        .req_o              (req),
        .grant_i            (grant),
        .out_valid_o        (out_valid),
        .out_data_o         (out_data),
        .out_last_o         (out_last),
        .cfg_starve_limit_i (limit),
        .starve_o           (starve),
        .err_spurious_o     (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {63'd0, in_ready}, {63'd0, (m_en && mq.size() < 4)});
        chk("req", {63'd0, req}, {63'd0, (mq.size() != 0)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("out_data", {32'd0, out_data}, {32'd0, m_od});
        chk("out_last", {63'd0, out_last}, {63'd0, m_ol});
        chk("starve", {63'd0, starve}, {63'd0, m_starve});
        chk("err_spurious", {63'd0, err}, {63'd0, m_err});
    endtask

    // One clock cycle: drive, check current outputs, advance the model.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit g);
        int          sz;
        bit          rdy;
        bit          rq;
        logic [32:0] b;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        grant    = g;
        #1;
        check_all();
        sz       = mq.size();
        rdy      = m_en && (sz < 4);
        rq       = (sz != 0);
        m_starve = (limit != 11'd0) && (m_cnt >= int'(limit));
        m_cnt    = (rq && !g) ? ((m_cnt < 2047) ? m_cnt + 1 : 2047) : 0;
        if (g && sz == 0) m_err = 1'b1;
        if (g && sz != 0) begin
            b    = mq.pop_front();
            m_ov = 1'b1;
            m_od = b[31:0];
            m_ol = b[32];
        end else begin
            m_ov = 1'b0;
        end
        if (v && rdy) mq.push_back({l, d});
        m_en   = 1'b1;
        prev_g = g;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        grant    = 1'b0;
        #1;
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_starve", {63'd0, starve}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        mq.delete();
        m_en = 1'b0; m_ov = 1'b0; m_od = 32'd0; m_ol = 1'b0;
        m_err = 1'b0; m_cnt = 0; m_starve = 1'b0; prev_g = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        m_en = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        grant    = 1'b0;
        limit    = 11'd0;
        do_reset();

        // Three beats then spaced grants
        step(1'b1, 32'hD000_0000, 1'b0, 1'b0);
        step(1'b1, 32'hD000_0001, 1'b0, 1'b0);
        step(1'b1, 32'hD000_0002, 1'b1, 1'b0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1);
            idle(1);
        end
        idle(2);

        // Fill, then a push colliding with a grant while full is refused
        for (int i = 0; i < 4; i++) step(1'b1, 32'hF000_0000 + i, (i == 3), 1'b0);
        idle(1);
        step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1);
            idle(1);
        end

        // Spurious grant is sticky through later traffic
        step(1'b0, 32'd0, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 32'h5A5A_0001, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);
        do_reset();

        // Starvation with limit 5, then disabled
        limit = 11'd5;
        step(1'b1, 32'h0000_57A5, 1'b1, 1'b0);
        idle(8);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);
        limit = 11'd0;
        step(1'b1, 32'h0000_57A6, 1'b1, 1'b0);
        idle(8);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        idle(2);

        // Randomized push/grant traffic with pointer wrap
        for (int i = 0; i < 120; i++) begin
            bit v;
            bit g;
            if (i % 15 == 0) limit = 11'($urandom_range(0, 6));
            v = bit'($urandom_range(0, 1));
            g = prev_g ? 1'b0 : bit'($urandom_range(0, 1));
            step(v, $urandom, bit'($urandom_range(0, 1)), g);
            chk("fill_bound", {63'd0, (mq.size() <= 4)}, 64'd1);
        end
        idle(2);

        // Reset with two beats pending; afterwards a grant pops nothing
        limit = 11'd3;
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b1, 1'b0);
        idle(5);
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
